// File: rtl/merger_out_line_packer.sv
// Packs P-record beats from the merger tree's output FIFO into 512-bit memory lines.
// A fill register assembles the next line while the out register waits for the memory handshake.
module merger_out_line_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int P          = 4,
    parameter int LINE_WORDS = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH-1:0]            i_base_addr,
    input  logic [31:0]                      i_num_records,
    output logic                             o_busy,
    output logic                             o_done,
    input  logic [P*DATA_WIDTH-1:0]          i_data,
    input  logic                             i_empty,
    output logic                             o_read,
    output logic                             o_wr_valid,
    output logic [ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] o_wr_data,
    input  logic                             i_wr_ready,
    output logic [31:0]                      o_lines_written
);

    localparam int BEAT_W = P * DATA_WIDTH;
    localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
    localparam int BPL    = LINE_WORDS / P;
    localparam int CNT_W  = (BPL > 1) ? $clog2(BPL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [31:0]           num_q, num_d;
    logic [31:0]           read_cnt_q, read_cnt_d;
    logic [31:0]           lines_q, lines_d;
    logic [LINE_W-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic                  fill_full_q, fill_full_d;
    logic [LINE_W-1:0]     out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  out_valid_q, out_valid_d;

    logic              rd;
    logic              last_beat;
    logic              out_free;
    logic              done;
    logic [LINE_W-1:0] merged;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            num_q       <= '0;
            read_cnt_q  <= '0;
            lines_q     <= '0;
            fill_q      <= '0;
            fill_cnt_q  <= '0;
            fill_full_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            num_q       <= num_d;
            read_cnt_q  <= read_cnt_d;
            lines_q     <= lines_d;
            fill_q      <= fill_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_full_q <= fill_full_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        num_d       = num_q;
        read_cnt_d  = read_cnt_q;
        lines_d     = lines_q;
        fill_d      = fill_q;
        fill_cnt_d  = fill_cnt_q;
        fill_full_d = fill_full_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        done        = 1'b0;

        // The out register is free if empty or its line is being accepted this cycle.
        out_free    = ~out_valid_q | i_wr_ready;
        out_valid_d = out_valid_q & ~i_wr_ready;
        if (out_valid_q && i_wr_ready) begin
            lines_d = lines_q + 32'd1;
        end

        rd        = (state_q == RUN) && !i_empty && (read_cnt_q != num_q) && !fill_full_q;
        last_beat = (fill_cnt_q == CNT_W'(BPL - 1)) || ((num_q - read_cnt_q) == 32'(P));
        merged    = fill_q;
        merged[fill_cnt_q * BEAT_W +: BEAT_W] = i_data;

        // A completed line bypasses the fill register when the out register can take it.
        if (fill_full_q && out_free) begin
            out_data_d  = fill_q;
            out_addr_d  = next_addr_q;
            out_valid_d = 1'b1;
            next_addr_d = next_addr_q + ADDR_WIDTH'(LINE_WORDS);
            fill_d      = '0;
            fill_full_d = 1'b0;
        end else if (rd) begin
            read_cnt_d = read_cnt_q + 32'(P);
            if (last_beat && out_free) begin
                out_data_d  = merged;
                out_addr_d  = next_addr_q;
                out_valid_d = 1'b1;
                next_addr_d = next_addr_q + ADDR_WIDTH'(LINE_WORDS);
                fill_d      = '0;
                fill_cnt_d  = '0;
            end else if (last_beat) begin
                fill_d      = merged;
                fill_cnt_d  = '0;
                fill_full_d = 1'b1;
            end else begin
                fill_d     = merged;
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    next_addr_d = i_base_addr;
                    num_d       = i_num_records;
                    read_cnt_d  = '0;
                    lines_d     = '0;
                    state_d     = (i_num_records != 32'd0) ? RUN : FLUSH;
                end
            end
            RUN: begin
                if (read_cnt_q == num_q && !fill_full_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_valid_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy          = (state_q != IDLE);
    assign o_done          = done;
    assign o_read          = rd;
    assign o_wr_valid      = out_valid_q;
    assign o_wr_addr       = out_addr_q;
    assign o_wr_data       = out_data_q;
    assign o_lines_written = lines_q;

endmodule

// File: tb/tb_merger_out_line_packer.sv
// Randomized scoreboard bench for merger_out_line_packer: a record-level model predicts
// every line write, and a monitor compares each accepted write against the queue.
module tb_merger_out_line_packer;

    localparam int DW     = 32;
    localparam int P      = 4;
    localparam int LW     = 16;
    localparam int AW     = 32;
    localparam int BEAT_W = P * DW;
    localparam int LINE_W = LW * DW;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [LINE_W-1:0] data;
    } line_t;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [AW-1:0]     i_base_addr;
    logic [31:0]       i_num_records;
    logic              o_busy;
    logic              o_done;
    logic [BEAT_W-1:0] i_data;
    logic              i_empty;
    logic              o_read;
    logic              o_wr_valid;
    logic [AW-1:0]     o_wr_addr;
    logic [LINE_W-1:0] o_wr_data;
    logic              i_wr_ready;
    logic [31:0]       o_lines_written;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int readyMode   = 0;
    int emptyMode   = 0;
    int linesSeen   = 0;
    int doneCount   = 0;
    int readLog[$];

    logic [BEAT_W-1:0] fifoQ[$];
    line_t             expQ[$];

    merger_out_line_packer #(.DATA_WIDTH(DW), .P(P), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_num_records  (i_num_records),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .i_data         (i_data),
        .i_empty        (i_empty),
        .o_read         (o_read),
        .o_wr_valid     (o_wr_valid),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .i_wr_ready     (i_wr_ready),
        .o_lines_written(o_lines_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory-side ready generator.
    initial begin
        i_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       i_wr_ready = 1'b1;
                1:       i_wr_ready = ($urandom_range(0, 2) != 0);
                default: i_wr_ready = 1'b0;
            endcase
        end
    end

    // Show-ahead FIFO model: o_read seen before an edge pops the head after it.
    initial begin
        logic willRead;
        i_empty = 1'b1;
        i_data  = '0;
        forever begin
            @(negedge clk);
            willRead = o_read;
            @(posedge clk);
            #1;
            if (willRead) begin
                if (fifoQ.size() > 0) void'(fifoQ.pop_front());
                readLog.push_back(cycle);
            end
            if (fifoQ.size() == 0) begin
                i_empty = 1'b1;
                i_data  = '0;
            end else begin
                i_empty = (emptyMode != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
                i_data  = fifoQ[0];
            end
        end
    end

    // Monitor: compares accepted writes against the scoreboard and checks stall stability.
    initial begin
        logic              prevStalled;
        logic [AW-1:0]     prevAddr;
        logic [LINE_W-1:0] prevData;
        line_t             e;
        prevStalled = 1'b0;
        prevAddr    = '0;
        prevData    = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                prevStalled = 1'b0;
            end else begin
                if (o_done) doneCount++;
                if (prevStalled) begin
                    checkOutput("stall_valid_held", o_wr_valid, 1'b1);
                    checkOutput("stall_addr_stable", o_wr_addr, prevAddr);
                    checkOutput("stall_data_stable", o_wr_data, prevData);
                end
                if (o_wr_valid && i_wr_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_write", 1'b1, 1'b0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("line_addr", o_wr_addr, e.addr);
                        checkOutput("line_data", o_wr_data, e.data);
                    end
                    linesSeen++;
                end
                prevStalled = o_wr_valid & ~i_wr_ready;
                prevAddr    = o_wr_addr;
                prevData    = o_wr_data;
            end
        end
    end

    // Builds the record stream, predicts the lines it must produce and pulses i_start.
    task automatic applyStimulus(input logic [AW-1:0] base, input int num);
        logic [31:0]       recs[];
        logic [BEAT_W-1:0] beat;
        line_t             e;
        recs = new[num];
        for (int n = 0; n < num; n++) recs[n] = $urandom;
        for (int b = 0; b < num / P; b++) begin
            beat = '0;
            for (int j = 0; j < P; j++) beat[j*DW +: DW] = recs[b*P + j];
            fifoQ.push_back(beat);
        end
        for (int l = 0; l < (num + LW - 1) / LW; l++) begin
            e.addr = base + AW'(l * LW);
            e.data = '0;
            for (int w = 0; w < LW; w++) begin
                if (l*LW + w < num) e.data[w*DW +: DW] = recs[l*LW + w];
            end
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        i_base_addr   = base;
        i_num_records = num;
        i_start       = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int d0);
        int budget;
        budget = 3000;
        while (doneCount == d0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput({name, "_timeout"}, 1'b1, 1'b0);
    endtask

    task automatic finishJob(input string name, input int num, input int d0, input int r0);
        waitDone(name, d0);
        repeat (3) @(negedge clk);
        checkOutput({name, "_lines_written"}, o_lines_written, (num + LW - 1) / LW);
        checkOutput({name, "_beats_read"}, readLog.size() - r0, num / P);
        checkOutput({name, "_scoreboard_empty"}, expQ.size(), 0);
        checkOutput({name, "_done_pulses"}, doneCount - d0, 1);
        checkOutput({name, "_idle"}, o_busy, 1'b0);
    endtask

    task automatic runJob(input string name, input logic [AW-1:0] base, input int num,
                          input bit midStart);
        int d0, r0;
        d0 = doneCount;
        r0 = readLog.size();
        applyStimulus(base, num);
        if (midStart) begin
            repeat (3) @(posedge clk);
            #1;
            i_base_addr   = ~base;
            i_num_records = num + P;
            i_start       = 1'b1;
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
        finishJob(name, num, d0, r0);
    endtask

    initial begin
        int d0, r0, l0, budget, num;
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_base_addr   = '0;
        i_num_records = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", o_busy, 1'b0);
        checkOutput("reset_done", o_done, 1'b0);
        checkOutput("reset_read", o_read, 1'b0);
        checkOutput("reset_wr_valid", o_wr_valid, 1'b0);
        checkOutput("reset_wr_addr", o_wr_addr, 0);
        checkOutput("reset_wr_data", o_wr_data, 0);
        checkOutput("reset_lines", o_lines_written, 0);
        i_rst = 1'b0;

        // Full-rate streaming: 16 beats must be read on consecutive cycles.
        r0 = readLog.size();
        runJob("stream", 32'h100, 64, 1'b0);
        if (readLog.size() - r0 == 16)
            checkOutput("stream_consecutive", readLog[r0 + 15] - readLog[r0], 15);

        // Backpressure on the first line: reading must stop after 8 beats.
        readyMode = 2;
        d0 = doneCount;
        r0 = readLog.size();
        applyStimulus(32'h100, 64);
        budget = 200;
        while (!o_wr_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("stall_first_valid", o_wr_valid, 1'b1);
        repeat (9) @(negedge clk);
        checkOutput("stall_beats_read", readLog.size() - r0, 8);
        readyMode = 0;
        finishJob("stall", 64, d0, r0);

        // Partial final line is zero-padded.
        runJob("partial", 32'h100, 24, 1'b0);

        // Empty job: immediate done, no reads, no writes.
        r0 = readLog.size();
        l0 = linesSeen;
        applyStimulus(32'h200, 0);
        @(negedge clk);
        checkOutput("zero_done", o_done, 1'b1);
        @(negedge clk);
        checkOutput("zero_done_once", o_done, 1'b0);
        checkOutput("zero_idle", o_busy, 1'b0);
        checkOutput("zero_reads", readLog.size() - r0, 0);
        checkOutput("zero_writes", linesSeen - l0, 0);

        // Reset mid-job discards everything, then a fresh job must run cleanly.
        l0 = linesSeen;
        d0 = doneCount;
        applyStimulus(32'h100, 64);
        budget = 500;
        while (linesSeen < l0 + 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("midreset_two_lines", linesSeen - l0, 2);
        i_rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_valid_low", o_wr_valid, 1'b0);
        checkOutput("midreset_idle", o_busy, 1'b0);
        i_rst = 1'b0;
        fifoQ.delete();
        expQ.delete();
        repeat (5) @(negedge clk);
        checkOutput("midreset_no_done", doneCount - d0, 0);
        runJob("after_reset", 32'h0, 16, 1'b0);

        // Randomized jobs with random ready/empty gaps, including address wrap.
        readyMode = 1;
        emptyMode = 1;
        for (int i = 0; i < 8; i++) begin
            num = (i == 1) ? 64 : P * $urandom_range(1, 24);
            runJob($sformatf("rand%0d", i), (i == 0) ? 32'hFFFF_FFE0 : $urandom, num, i == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
